// File: rtl/motor_ramp_controller.sv
// motor_ramp_controller: weight-banded motor power ramp with fixed dwell per step, hold, ramp-down and overload fault.
module motor_ramp_controller #(
  parameter int STEP_CYCLES = 8,
  parameter int BAND        = 200,
  parameter int OVERLOAD    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] weight,
  input  logic        run_req,
  output logic        run_ack,
  output logic [2:0]  powerlevel,
  output logic [7:0]  motor,
  output logic        busy,
  output logic        overload
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RAMP_UP   = 3'd1;
  localparam logic [2:0] HOLD      = 3'd2;
  localparam logic [2:0] RAMP_DOWN = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;
  logic [2:0] state_q, state_d, level_q, level_d, target_q, target_d;
  logic [7:0] cnt_q, cnt_d, motor_q, motor_d;
  logic       run_ack_q, run_ack_d, busy_q, busy_d, overload_q, overload_d;
  logic       step;
  assign step = cnt_q == 8'(STEP_CYCLES - 1);
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    run_ack_d = 1'b0;
    case (state_q)
      IDLE: if (run_req) begin
        if (weight >= 13'(OVERLOAD)) state_d = FAULT;
        else begin
          target_d = 3'(weight / 13'(BAND)) + 3'd1;
          cnt_d    = 8'd0;
          state_d  = RAMP_UP;
        end
      end
      // Dropping run_req wins over a step landing on the same edge.
      RAMP_UP: if (!run_req) begin
        state_d = RAMP_DOWN;
        cnt_d   = 8'd0;
      end else if (step) begin
        cnt_d   = 8'd0;
        level_d = level_q + 3'd1;
        if (level_q + 3'd1 == target_q) begin
          state_d   = HOLD;
          run_ack_d = 1'b1;
        end
      end else cnt_d = cnt_q + 8'd1;
      HOLD: if (!run_req) begin
        state_d = RAMP_DOWN;
        cnt_d   = 8'd0;
      end
      RAMP_DOWN: if (level_q == 3'd0) state_d = IDLE;
      else if (step) begin
        cnt_d   = 8'd0;
        level_d = level_q - 3'd1;
        state_d = level_q == 3'd1 ? IDLE : RAMP_DOWN;
      end else cnt_d = cnt_q + 8'd1;
      FAULT: begin
        level_d = 3'd0;
        state_d = run_req ? FAULT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    motor_d    = 8'd1 << level_d;
    busy_d     = state_d != IDLE;
    overload_d = state_d == FAULT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      level_q    <= 3'd0;
      target_q   <= 3'd0;
      cnt_q      <= 8'd0;
      motor_q    <= 8'd1;
      run_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      overload_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      motor_q    <= motor_d;
      run_ack_q  <= run_ack_d;
      busy_q     <= busy_d;
      overload_q <= overload_d;
    end
  end
  assign run_ack    = run_ack_q;
  assign powerlevel = level_q;
  assign motor      = motor_q;
  assign busy       = busy_q;
  assign overload   = overload_q;
endmodule

// File: tb/tb_motor_ramp_controller.sv
// tb_motor_ramp_controller: directed literal checks plus randomized run against a timeline-based reference model.
module tb_motor_ramp_controller;
  localparam int STEP = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] weight = '0;
  logic        run_req = 1'b0;
  logic        run_ack, busy, overload;
  logic [2:0]  powerlevel;
  logic [7:0]  motor;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  motor_ramp_controller #(.STEP_CYCLES(STEP), .BAND(200), .OVERLOAD(1000)) dut (
    .clk(clk), .rst_n(rst_n), .weight(weight), .run_req(run_req),
    .run_ack(run_ack), .powerlevel(powerlevel), .motor(motor),
    .busy(busy), .overload(overload)
  );
  always #5 clk = ~clk;
  // Model phases: 0 idle, 1 rising, 2 holding, 3 falling, 4 fault.
  // Level is derived from time elapsed in the phase, not from a step counter.
  typedef struct {
    int mode;
    int lvl;
    int tgt;
    int t;
    int l0;
    int ack;
  } model_t;
  model_t m = '{0, 0, 0, 0, 0, 0};
  function automatic model_t nxt(model_t c, logic rn, logic rr, int w);
    model_t n = c;
    n.ack = 0;
    if (!rn) return '{0, 0, 0, 0, 0, 0};
    case (c.mode)
      0: if (rr) begin
        if (w >= 1000) n.mode = 4;
        else begin
          n.tgt = w / 200 + 1;
          n.t = 0;
          n.mode = 1;
        end
      end
      1: if (!rr) begin
        n.mode = 3; n.l0 = c.lvl; n.t = 0;
      end else begin
        n.t = c.t + 1;
        n.lvl = n.t / STEP;
        if (n.lvl == c.tgt) begin n.mode = 2; n.ack = 1; end
      end
      2: if (!rr) begin n.mode = 3; n.l0 = c.lvl; n.t = 0; end
      3: if (c.l0 == 0) n.mode = 0;
      else begin
        n.t = c.t + 1;
        n.lvl = c.l0 - n.t / STEP;
        if (n.lvl == 0) n.mode = 0;
      end
      4: begin n.lvl = 0; if (!rr) n.mode = 0; end
      default: n.mode = 0;
    endcase
    return n;
  endfunction
  always @(posedge clk) m <= nxt(m, rst_n, run_req, int'(weight));
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("model_level", 8'(powerlevel), 8'(m.lvl));
    chk("model_motor", motor, 8'(1 << m.lvl));
    chk("model_ack", 8'(run_ack), 8'(m.ack));
    chk("model_busy", 8'(busy), 8'(m.mode != 0));
    chk("model_overload", 8'(overload), 8'(m.mode == 4));
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  int bw[5] = '{199, 200, 799, 800, 999};
  int bt[5] = '{1, 2, 4, 5, 5};
  initial begin
    cyc(2);
    chk_en = 1'b1;
    chk("rst_level", 8'(powerlevel), 8'd0);
    chk("rst_motor", motor, 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_overload", 8'(overload), 8'd0);
    chk("rst_ack", 8'(run_ack), 8'd0);
    rst_n = 1'b1; weight = 13'd450; run_req = 1'b1;
    cyc(9);
    chk("up_l1", 8'(powerlevel), 8'd1);
    cyc(8);
    chk("up_l2", 8'(powerlevel), 8'd2);
    chk("up_l2_noack", 8'(run_ack), 8'd0);
    cyc(8);
    chk("up_l3", 8'(powerlevel), 8'd3);
    chk("up_ack", 8'(run_ack), 8'd1);
    chk("up_motor", motor, 8'b0000_1000);
    weight = 13'd900;
    cyc(3);
    chk("hold_ack_low", 8'(run_ack), 8'd0);
    chk("hold_level", 8'(powerlevel), 8'd3);
    run_req = 1'b0;
    cyc(9);
    chk("down_l2", 8'(powerlevel), 8'd2);
    cyc(8);
    chk("down_l1", 8'(powerlevel), 8'd1);
    cyc(8);
    chk("down_l0", 8'(powerlevel), 8'd0);
    chk("down_idle", 8'(busy), 8'd0);
    weight = 13'd1000; run_req = 1'b1;
    cyc(1);
    chk("ovl_flag", 8'(overload), 8'd1);
    chk("ovl_level", 8'(powerlevel), 8'd0);
    weight = 13'd100;
    cyc(4);
    chk("ovl_sticky", 8'(overload), 8'd1);
    run_req = 1'b0;
    cyc(1);
    chk("ovl_clear", 8'(overload), 8'd0);
    chk("ovl_idle", 8'(busy), 8'd0);
    weight = 13'd900; run_req = 1'b1;
    cyc(17);
    chk("abort_l2", 8'(powerlevel), 8'd2);
    cyc(7);
    run_req = 1'b0;
    cyc(1);
    chk("abort_no_step", 8'(powerlevel), 8'd2);
    chk("abort_no_ack", 8'(run_ack), 8'd0);
    cyc(16);
    chk("abort_l0", 8'(powerlevel), 8'd0);
    chk("abort_idle", 8'(busy), 8'd0);
    for (int i = 0; i < 5; i++) begin
      weight = 13'(bw[i]); run_req = 1'b1;
      cyc(1 + bt[i] * STEP);
      chk($sformatf("band_%0d", bw[i]), 8'(powerlevel), 8'(bt[i]));
      chk($sformatf("band_ack_%0d", bw[i]), 8'(run_ack), 8'd1);
      run_req = 1'b0;
      cyc(1 + bt[i] * STEP);
      chk($sformatf("band_idle_%0d", bw[i]), 8'(busy), 8'd0);
    end
    weight = 13'd900; run_req = 1'b1;
    cyc(1 + 4 * STEP);
    chk("mid_l4", 8'(powerlevel), 8'd4);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_level", 8'(powerlevel), 8'd0);
    chk("mid_rst_motor", motor, 8'd1);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1; run_req = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 59) == 0) run_req = ~run_req;
      weight = 13'($urandom_range(0, 1199));
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
